// File: rtl/debounce_bank.sv
// debounce_bank: N-channel button conditioner (2-flop sync, tick-based debounce, press/release pulses).
// Define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat generator; otherwise repeat_1p is 0.
module debounce_bank #(
    parameter int N         = 4,
    parameter int DIV       = 1,
    parameter int STABLE    = 3,
    parameter int REP_DELAY = 500,
    parameter int REP_RATE  = 100
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] inp,
    output logic [N-1:0] level,
    output logic [N-1:0] press_1p,
    output logic [N-1:0] release_1p,
    output logic [N-1:0] repeat_1p
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [N-1:0]  s1, s2;
    logic [N-1:0]  level_d;
    logic [PW-1:0] pre_cnt;
    logic          tick;

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= inp;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)       pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = (pre_cnt == PRE_LAST);

    // Edges are taken from the registered level, so pulses follow the level change by one cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            level_d    <= '0;
            press_1p   <= '0;
            release_1p <= '0;
        end else begin
            level_d    <= level;
            press_1p   <= level & ~level_d;
            release_1p <= ~level & level_d;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

    typedef enum logic {R_IDLE, R_HOLD} rep_state_t;
`endif

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl;

        // Any tick where s2 agrees with the accepted level restarts the stability window.
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (tick) begin
                if (s2[g] == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl <= s2[g];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level[g] = lvl;

`ifdef DEBOUNCE_REPEAT_EN
        rep_state_t    state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          first_q, first_d;
        logic          fire;
        logic          rep_q;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                state_q <= R_IDLE;
                rcnt_q  <= '0;
                first_q <= 1'b1;
                rep_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                first_q <= first_d;
                rep_q   <= fire;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                R_IDLE:  if (lvl)  state_d = R_HOLD;
                R_HOLD:  if (!lvl) state_d = R_IDLE;
                default: state_d = R_IDLE;
            endcase
        end

        // first_q selects the initial hold delay versus the steady repeat period.
        always_comb begin
            fire    = 1'b0;
            rcnt_d  = rcnt_q;
            first_d = first_q;
            case (state_q)
                R_HOLD: begin
                    if (!lvl) begin
                        rcnt_d = '0;
                    end else if (tick) begin
                        if (rcnt_q == (first_q ? DELAY_LAST : RATE_LAST)) begin
                            fire    = 1'b1;
                            rcnt_d  = '0;
                            first_d = 1'b0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    rcnt_d  = '0;
                    first_d = 1'b1;
                end
            endcase
        end

        assign repeat_1p[g] = rep_q;
`endif
    end

`ifndef DEBOUNCE_REPEAT_EN
    assign repeat_1p = '0;
`endif

endmodule
